// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared definitions for the GPIO register-bus arbiter: FSM state encoding,
// default response timeout and an index-width helper.
package gpio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int TIMEOUT_DEFAULT = 16;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_bus_arbiter_rr_picker.sv
// Round-robin picker: scans requesters starting one past the last grant,
// wrapping modulo N, and returns the first active index.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic [IW-1:0] cand [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = IW'((int'(last) + gi + 1) % N);
    end

    // Scan from the farthest candidate down so the nearest active one wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Arbitrates N_REQ requesters onto one GPIO register bus, one transaction
// outstanding at a time, with a response timeout while waiting for completion.
module gpio_bus_arbiter
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ-1:0]          req_we_i,
    input  logic [N_REQ-1:0][AW-1:0]  req_addr_i,
    input  logic [N_REQ-1:0][DW-1:0]  req_wdata_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic [N_REQ-1:0]          rsp_valid_o,
    output logic [DW-1:0]             rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      s_valid_o,
    output logic                      s_we_o,
    output logic [AW-1:0]             s_addr_o,
    output logic [DW-1:0]             s_wdata_o,
    input  logic                      s_ready_i,
    input  logic                      s_rvalid_i,
    input  logic [DW-1:0]             s_rdata_i
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      win_q, win_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_picker (
        .req    (req_valid_i),
        .last   (last_q),
        .winner (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    win_d   = pick_idx;
                    we_d    = req_we_i[pick_idx];
                    addr_d  = req_addr_i[pick_idx];
                    wdata_d = req_wdata_i[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (s_ready_i) begin
                    last_d  = win_q;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (s_rvalid_i) begin
                    rsp_valid_d = N_REQ'(1) << win_q;
                    rdata_d     = we_q ? '0 : s_rdata_i;
                    state_d     = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d = N_REQ'(1) << win_q;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IW'(N_REQ - 1);
            win_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Acceptance is signalled in the same cycle as the bus handshake.
    assign req_ready_o = (state_q == ISSUE && s_ready_i) ? (N_REQ'(1) << win_q) : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign s_valid_o   = (state_q == ISSUE);
    assign s_we_o      = we_q;
    assign s_addr_o    = addr_q;
    assign s_wdata_o   = wdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter: single read, contention, backpressure,
// write, timeout with late response, and reset during WAIT.
module tb_gpio_bus_arbiter;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [2:0]        req_valid_i = '0;
    logic [2:0]        req_we_i = '0;
    logic [2:0][7:0]   req_addr_i = '0;
    logic [2:0][31:0]  req_wdata_i = '0;
    logic [2:0]        req_ready_o;
    logic [2:0]        rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              s_valid_o;
    logic              s_we_o;
    logic [7:0]        s_addr_o;
    logic [31:0]       s_wdata_o;
    logic              s_ready_i = 1'b0;
    logic              s_rvalid_i = 1'b0;
    logic [31:0]       s_rdata_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpio_bus_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .s_valid_o   (s_valid_o),
        .s_we_o      (s_we_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_ready_i   (s_ready_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with the request already driven. lat > 0: slave
    // completes lat cycles after accept; lat <= 0: slave never completes.
    // Returns in the cycle carrying the response pulse.
    task automatic run_txn(input int idx, input bit drop, input int stall, input int lat,
                           input logic [31:0] slv_rdata, input logic [31:0] exp_rdata);
        logic [2:0]  oh;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wdata;
        oh        = 3'b001 << idx;
        exp_we    = req_we_i[idx];
        exp_addr  = req_addr_i[idx];
        exp_wdata = req_wdata_i[idx];
        s_ready_i = (stall == 0);
        tick;
        for (int i = 0; i < stall; i++) begin
            check("bp_valid", s_valid_o, 1);
            check("bp_addr", s_addr_o, exp_addr);
            check("bp_we", s_we_o, exp_we);
            check("bp_no_ready", req_ready_o, 0);
            tick;
        end
        s_ready_i = 1'b1;
        #1;
        check("iss_valid", s_valid_o, 1);
        check("iss_we", s_we_o, exp_we);
        check("iss_addr", s_addr_o, exp_addr);
        check("iss_wdata", s_wdata_o, exp_wdata);
        check("iss_ready", req_ready_o, oh);
        if (drop) req_valid_i[idx] = 1'b0;
        tick;
        s_ready_i = 1'b0;
        #1;
        check("wait_valid", s_valid_o, 0);
        check("wait_ready", req_ready_o, 0);
        if (lat > 0) begin
            for (int i = 1; i < lat; i++) begin
                check("wait_no_rsp", rsp_valid_o, 0);
                tick;
            end
            s_rvalid_i = 1'b1;
            s_rdata_i  = slv_rdata;
            tick;
            s_rvalid_i = 1'b0;
            s_rdata_i  = '0;
            check("rsp_valid", rsp_valid_o, oh);
            check("rsp_rdata", rsp_rdata_o, exp_rdata);
            check("rsp_err", rsp_err_o, 0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                check("to_no_rsp", rsp_valid_o, 0);
                tick;
            end
            check("to_valid", rsp_valid_o, oh);
            check("to_err", rsp_err_o, 1);
            check("to_rdata", rsp_rdata_o, 0);
        end
        $display("txn: req %0d we %0b addr 0x%02h stall %0d -> rsp 0x%08h err %0b",
                 idx, exp_we, exp_addr, stall, rsp_rdata_o, rsp_err_o);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_s_valid", s_valid_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        check("rst_err", rsp_err_o, 0);
        check("rst_addr", s_addr_o, 0);
        tick;
        tick;
        rst = 1'b0;

        // Single read from requester 0
        req_addr_i[0] = 8'h04;
        req_valid_i   = 3'b001;
        run_txn(0, 1'b1, 0, 2, 32'h0000_00A5, 32'h0000_00A5);
        tick;
        check("hold_rsp_valid", rsp_valid_o, 0);
        check("hold_rdata", rsp_rdata_o, 32'h0000_00A5);
        check("idle_s_valid", s_valid_o, 0);

        // Contention after a fresh reset: 0,1,2 then 0
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst2_rdata", rsp_rdata_o, 0);
        for (int i = 0; i < 3; i++) req_addr_i[i] = 8'h20 + 8'(i);
        req_valid_i = 3'b111;
        run_txn(0, 1'b0, 0, 1, 32'h100, 32'h100);
        run_txn(1, 1'b0, 0, 1, 32'h101, 32'h101);
        run_txn(2, 1'b0, 0, 1, 32'h102, 32'h102);
        run_txn(0, 1'b0, 0, 1, 32'h103, 32'h103);
        req_valid_i = 3'b000;
        tick;
        check("cont_idle", s_valid_o, 0);

        // Backpressure: five cycles of s_ready_i low
        req_addr_i[1] = 8'h30;
        req_valid_i   = 3'b010;
        run_txn(1, 1'b1, 5, 1, 32'h1234_5678, 32'h1234_5678);

        // Write from requester 2
        req_we_i       = 3'b100;
        req_addr_i[2]  = 8'h10;
        req_wdata_i[2] = 32'h0000_000F;
        req_valid_i    = 3'b100;
        run_txn(2, 1'b1, 0, 1, 32'hDEAD_BEEF, 32'h0);
        req_we_i = 3'b000;

        // Timeout, then a late completion that must be ignored
        req_addr_i[0] = 8'h08;
        req_valid_i   = 3'b001;
        run_txn(0, 1'b1, 0, 0, 32'h0, 32'h0);
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'h77;
        tick;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        check("late_rsp_valid", rsp_valid_o, 0);
        check("late_err", rsp_err_o, 0);
        check("late_rdata", rsp_rdata_o, 0);
        check("late_s_valid", s_valid_o, 0);

        // Reset while requester 0's read is in WAIT
        req_addr_i[0] = 8'h0C;
        req_valid_i   = 3'b001;
        s_ready_i     = 1'b1;
        tick;
        req_valid_i = 3'b000;
        tick;
        s_ready_i = 1'b0;
        check("rw_addr", s_addr_o, 8'h0C);
        tick;
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'h99;
        rst        = 1'b1;
        #1;
        check("rw_s_valid", s_valid_o, 0);
        check("rw_s_addr", s_addr_o, 0);
        check("rw_rsp_valid", rsp_valid_o, 0);
        check("rw_req_ready", req_ready_o, 0);
        tick;
        check("rw_no_rsp", rsp_valid_o, 0);
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        rst        = 1'b0;
        req_addr_i[1] = 8'h44;
        req_valid_i   = 3'b011;
        run_txn(0, 1'b1, 0, 1, 32'h55, 32'h55);
        run_txn(1, 1'b1, 0, 1, 32'h66, 32'h66);
        req_valid_i = 3'b000;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
